// File: rtl/serial_frame_rx_4b.sv
// serial_frame_rx_4b: start/stop framed serial receiver with one-entry valid/ready holding register
module serial_frame_rx_4b #(
    parameter int DATA_W = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              bit_en,
    input  logic              ready,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t state;
    logic [2:0] cnt;
    logic [DATA_W-1:0] sh, sh_next;
    logic free;
    always_comb begin
        sh_next = LSB_FIRST ? {sin, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], sin};
        free = !valid || ready;
    end
    assign busy = (state != IDLE);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sh      <= '0;
            data    <= '0;
            valid   <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (clr_err) ovr_err <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: if (!sin) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                    DATA: begin
                        sh  <= sh_next;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'(DATA_W-1)) state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // a load into a freed register overrides the transfer's clear of valid
                        if (!sin) frm_err <= 1'b1;
                        else if (free) begin
                            data  <= sh;
                            valid <= 1'b1;
                        end else ovr_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx_4b.sv
// tb_serial_frame_rx_4b: table-driven and directed checks of the framed serial receiver
module tb_serial_frame_rx_4b;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b1, bit_en = 1'b0, ready = 1'b0, clr_err = 1'b0;
    logic [3:0] data;
    logic valid, frm_err, ovr_err, busy;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    serial_frame_rx_4b dut (
        .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en), .ready(ready), .clr_err(clr_err),
        .data(data), .valid(valid), .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
    );

    typedef struct {
        logic [3:0] word;
        logic       stop_bit;
        logic [3:0] exp_data;
        logic       exp_valid;
        logic       exp_frm;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic strobe(input logic b, input int r = -1);
        @(negedge clk);
        sin = b;
        bit_en = 1'b1;
        if (r >= 0) ready = r[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_en = 1'b0;
        sin = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    // LSB-first frame: start, w[0..3], stop; gap idle cycles before every strobe
    task automatic send_frame(input logic [3:0] w, input logic stop_bit, input int gap, input int stop_ready);
        for (int i = 0; i < 6; i++) begin
            repeat (gap) idle_cycle();
            strobe(i == 0 ? 1'b0 : i == 5 ? stop_bit : w[i-1], i == 5 ? stop_ready : -1);
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        bit_en = 1'b0;
        sin = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_consumed"}, 8'(valid), 8'd0);
        @(negedge clk);
        ready = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{4'hD, 1'b1, 4'hD, 1'b1, 1'b0};
        vecs[1] = '{4'hF, 1'b0, 4'hD, 1'b0, 1'b1};
        vecs[2] = '{4'h3, 1'b1, 4'h3, 1'b1, 1'b0};
        vecs[3] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{4'h7, 1'b1, 4'h7, 1'b1, 1'b0};

        #12;
        chk("rst_data", 8'(data), 8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // reset in the middle of a frame
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        chk("mid_busy", 8'(busy), 8'd1);
        #2;
        rst = 1'b0;
        bit_en = 1'b0;
        #1;
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_outs", {data, valid, frm_err, ovr_err}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'hA, 1'b1, 0, -1);
        chk("after_rst_data", 8'(data), 8'hA);
        chk("after_rst_valid", 8'(valid), 8'd1);
        consume("after_rst");

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].word, vecs[i].stop_bit, 0, -1);
            chk($sformatf("vec%0d_data", i), 8'(data), 8'(vecs[i].exp_data));
            chk($sformatf("vec%0d_valid", i), 8'(valid), 8'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_frm", i), 8'(frm_err), 8'(vecs[i].exp_frm));
            chk($sformatf("vec%0d_ovr", i), 8'(ovr_err), 8'd0);
            consume($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_frm_end", i), 8'(frm_err), 8'd0);
            chk($sformatf("vec%0d_busy", i), 8'(busy), 8'd0);
        end

        // overrun: second word dropped while first is held
        send_frame(4'h5, 1'b1, 0, -1);
        send_frame(4'h9, 1'b1, 0, -1);
        chk("ovr_data", 8'(data), 8'h5);
        chk("ovr_valid", 8'(valid), 8'd1);
        chk("ovr_flag", 8'(ovr_err), 8'd1);
        @(negedge clk);
        bit_en = 1'b0;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_cleared", 8'(ovr_err), 8'd0);
        chk("ovr_hold_data", 8'(data), 8'h5);
        @(negedge clk);
        clr_err = 1'b0;
        consume("ovr");
        chk("ovr_xfer_data", 8'(data), 8'h5);

        // overrun coinciding with clr_err keeps the flag set
        send_frame(4'h2, 1'b1, 0, -1);
        clr_err = 1'b1;
        send_frame(4'h4, 1'b1, 0, -1);
        chk("set_wins", 8'(ovr_err), 8'd1);
        chk("set_wins_data", 8'(data), 8'h2);
        @(negedge clk);
        bit_en = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_after", 8'(ovr_err), 8'd0);
        clr_err = 1'b0;
        consume("set_wins");

        // ready held high through back-to-back frames
        ready = 1'b1;
        send_frame(4'h6, 1'b1, 0, -1);
        chk("b2b_first", 8'(data), 8'h6);
        chk("b2b_first_v", 8'(valid), 8'd1);
        send_frame(4'hC, 1'b1, 0, -1);
        chk("b2b_second", 8'(data), 8'hC);
        chk("b2b_second_v", 8'(valid), 8'd1);
        chk("b2b_ovr", 8'(ovr_err), 8'd0);
        ready = 1'b0;
        consume("b2b");

        // transfer and load on the same edge
        send_frame(4'h6, 1'b1, 0, -1);
        send_frame(4'hC, 1'b1, 0, 1);
        chk("simul_data", 8'(data), 8'hC);
        chk("simul_valid", 8'(valid), 8'd1);
        chk("simul_ovr", 8'(ovr_err), 8'd0);
        consume("simul");

        // sparse strobes with noise on sin between them
        send_frame(4'h8, 1'b1, 3, -1);
        chk("sparse_data", 8'(data), 8'h8);
        chk("sparse_valid", 8'(valid), 8'd1);
        consume("sparse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
